addsub_result_accumulator: RTL

- Downstream consumer of the add/sub select stage: takes each add-or-subtract result word as a two's-complement sample.
- Accumulates a frame of COUNT samples and presents the frame total with a sticky overflow flag.
- Upstream interface: valid/ready. Downstream interface: valid/ready, with the output held until taken.

---
 rtl/addsub_result_accumulator_if.sv | 24 ++
 rtl/addsub_result_accumulator.sv | 96 +++++++++
 2 files changed

// File: rtl/addsub_result_accumulator_if.sv
// Sample-in / frame-total-out handshake bundle for the add/sub result accumulator.
// master drives samples and accepts results; slave is the accumulator.
interface addsub_result_accumulator_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/addsub_result_accumulator.sv
// Sums frames of COUNT signed samples, then holds the total and a sticky
// signed-overflow flag until the downstream side takes it.
module addsub_result_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned COUNT     = 4,
    parameter int unsigned ACC_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    addsub_result_accumulator_if.slave   bus
);
    localparam int unsigned CntW = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic {StAccum, StHold} state_e;

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic signed [ACC_WIDTH-1:0] ext, add;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        ovf_acc_q, ovf_acc_d;
    logic                        ovf_q, ovf_d;
    logic                        add_ovf, accept, last;

    assign ext    = ACC_WIDTH'($signed(bus.in_data));
    assign add    = acc_q + ext;
    // Overflow: operands agree in sign but the wrapped result does not.
    assign add_ovf = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                     (add[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    assign accept = (state_q == StAccum) && bus.in_valid;
    assign last   = (cnt_q == CntW'(COUNT - 1));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    if (last) begin
                        sum_d     = add;
                        ovf_d     = ovf_acc_q | add_ovf;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_acc_d = 1'b0;
                        state_d   = StHold;
                    end else begin
                        acc_d     = add;
                        cnt_d     = cnt_q + CntW'(1);
                        ovf_acc_d = ovf_acc_q | add_ovf;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
        // Frame abort wins over accepts and over a pending output handshake.
        if (clear) begin
            state_d   = StAccum;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAccum;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StAccum);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
endmodule
